// File: rtl/score_digit_renderer_pkg.sv
// Shared constants and types for the score digit renderer: sprite geometry,
// ROM addressing, score limits and the BCD conversion FSM encoding.
package score_render_pkg;
  localparam int DIGIT_W     = 8;
  localparam int DIGIT_H     = 16;
  localparam int DIGIT_WORDS = 128;
  localparam int NUM_ROM_AW  = 11;
  localparam int SCORE_MAX   = 9999;
  localparam int SCORE_W     = 14;
  localparam int NUM_DIGITS  = 4;
  localparam int BCD_W       = 4 * NUM_DIGITS;
  localparam int PIX_W       = 8;
  localparam int HCOUNT_W    = 11;
  localparam int VCOUNT_W    = 10;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_t;
endpackage

// File: rtl/score_digit_renderer_if.sv
// Beam, score-write, ROM and pixel signals of the score renderer; the renderer
// is the slave side, the VGA/game environment the master side.
interface score_digit_renderer_if;
  import score_render_pkg::*;

  logic [HCOUNT_W-1:0]   hcount;
  logic [VCOUNT_W-1:0]   vcount;
  logic                  score_we;
  logic [SCORE_W-1:0]    score_in;
  logic                  busy;
  logic [NUM_ROM_AW-1:0] num_address;
  logic [PIX_W-1:0]      num_readdata;
  logic                  pixel_valid;
  logic [PIX_W-1:0]      pixel_color;

  modport slave (
    input  hcount, vcount, score_we, score_in, num_readdata,
    output busy, num_address, pixel_valid, pixel_color
  );

  modport master (
    output hcount, vcount, score_we, score_in, num_readdata,
    input  busy, num_address, pixel_valid, pixel_color
  );
endinterface

// File: rtl/score_digit_renderer_bcd.sv
// Sequential double-dabble: 14-bit binary to four BCD digits, one add-3/shift
// per cycle. A start while busy restarts with the new value.
module bcd_convert_seq
  import score_render_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin_in,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd_out
);
  conv_state_t        state, state_nxt;
  logic [3:0]         shift_cnt;
  logic [SCORE_W-1:0] bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_adj;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_sr[i*4 +: 4] >= 4'd5) ? bcd_sr[i*4 +: 4] + 4'd3
                                                     : bcd_sr[i*4 +: 4];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CONV_IDLE:   if (start) state_nxt = CONV_SHIFT;
      CONV_SHIFT:  if (start) state_nxt = CONV_SHIFT;
                   else if (shift_cnt == 4'(SCORE_W - 1)) state_nxt = CONV_COMMIT;
      CONV_COMMIT: state_nxt = start ? CONV_SHIFT : CONV_IDLE;
      default:     state_nxt = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CONV_IDLE;
      shift_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start)                    shift_cnt <= '0;
      else if (state == CONV_SHIFT) shift_cnt <= shift_cnt + 4'd1;
    end
  end

  // Shift register carries no reset: contents are meaningless outside SHIFT/COMMIT.
  always_ff @(posedge clk) begin
    if (start) begin
      bin_sr <= bin_in;
      bcd_sr <= '0;
    end else if (state == CONV_SHIFT) begin
      {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
    end
  end

  assign busy    = (state != CONV_IDLE);
  assign done    = (state == CONV_COMMIT);
  assign bcd_out = bcd_sr;
endmodule

// File: rtl/score_digit_renderer.sv
// Score box renderer: holds the score, maps beam coordinates to sprite-ROM
// addresses and returns opaque digit pixels with a fixed 3-cycle latency.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN hides leading zero digits.
module score_digit_renderer
  import score_render_pkg::*;
#(
  parameter int               X0         = 160,
  parameter int               Y0         = 8,
  parameter int               DIGIT_GAP  = 2,
  parameter logic [PIX_W-1:0] TRANSP_IDX = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  score_digit_renderer_if.slave bus
);
  localparam int PITCH = DIGIT_W + DIGIT_GAP;

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] v);
    return (v > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : v;
  endfunction

  logic [SCORE_W-1:0]  score_sat;
  logic                conv_busy, conv_done;
  logic [BCD_W-1:0]    conv_bcd;
  logic [BCD_W-1:0]    disp_bcd;

  logic [HCOUNT_W-1:0] col_p0, slot_full_p0, x_full_p0;
  logic [VCOUNT_W-1:0] row_p0;
  logic                in_box_p0, blank_p0;
  bcd_digit_t          digit_p0;
  logic                vld_p1, vld_p2;

  assign score_sat = sat_score(bus.score_in);

  bcd_convert_seq u_bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (bus.score_we),
    .bin_in  (score_sat),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  assign bus.busy = conv_busy;

  // All four digits swap together so the display never shows a torn score.
  always_ff @(posedge clk) begin
    if (reset)          disp_bcd <= '0;
    else if (conv_done) disp_bcd <= conv_bcd;
  end

  // ---- stage p0: beam to box-relative slot/column/row ----
  always_comb begin
    col_p0       = bus.hcount - HCOUNT_W'(X0);
    row_p0       = bus.vcount - VCOUNT_W'(Y0);
    slot_full_p0 = col_p0 / HCOUNT_W'(PITCH);
    x_full_p0    = col_p0 % HCOUNT_W'(PITCH);
    in_box_p0    = (bus.hcount >= HCOUNT_W'(X0)) && (bus.vcount >= VCOUNT_W'(Y0)) &&
                   (slot_full_p0 < HCOUNT_W'(NUM_DIGITS)) &&
                   (x_full_p0 < HCOUNT_W'(DIGIT_W)) &&
                   (row_p0 < VCOUNT_W'(DIGIT_H));
    case (slot_full_p0[1:0])
      2'd0:    digit_p0 = disp_bcd[15:12];
      2'd1:    digit_p0 = disp_bcd[11:8];
      2'd2:    digit_p0 = disp_bcd[7:4];
      default: digit_p0 = disp_bcd[3:0];
    endcase
  end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  // A slot is blank while it and every more-significant digit are zero; units never blank.
  always_comb begin
    blank_p0 = 1'b0;
    case (slot_full_p0[1:0])
      2'd0:    blank_p0 = (disp_bcd[15:12] == 4'd0);
      2'd1:    blank_p0 = (disp_bcd[15:8] == 8'd0);
      2'd2:    blank_p0 = (disp_bcd[15:4] == 12'd0);
      default: blank_p0 = 1'b0;
    endcase
  end
`else
  assign blank_p0 = 1'b0;
`endif

  // ---- stage p1: ROM address, held while the beam is outside the box ----
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.num_address <= '0;
      vld_p1          <= 1'b0;
    end else begin
      vld_p1 <= in_box_p0 & ~blank_p0;
      if (in_box_p0) bus.num_address <= {digit_p0, row_p0[3:0], x_full_p0[2:0]};
    end
  end

  // ---- stage p2: ROM access cycle ----
  always_ff @(posedge clk) begin
    if (reset) vld_p2 <= 1'b0;
    else       vld_p2 <= vld_p1;
  end

  // ---- stage p3: pixel output ----
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pixel_color <= '0;
      bus.pixel_valid <= 1'b0;
    end else begin
      bus.pixel_color <= bus.num_readdata;
      bus.pixel_valid <= vld_p2 && (bus.num_readdata != TRANSP_IDX);
    end
  end
endmodule
